// File: rtl/usb_hc_status_pkg.sv
// Shared constants for the USB host controller port status logic.
// Connect-state encodings and debounce FSM states.
package usb_hc_status_pkg;

    localparam logic [1:0] CONNECT_DISCONNECT = 2'b00;
    localparam logic [1:0] CONNECT_LOW_SPEED  = 2'b01;
    localparam logic [1:0] CONNECT_FULL_SPEED = 2'b10;
    localparam logic [1:0] CONNECT_SE1_ERR    = 2'b11;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_DEBOUNCE = 1'b1
    } dbState_t;

endpackage

// File: rtl/usb_port_debounce.sv
// Per-port connect-state debouncer with sticky W1C change flags.
// Also edge-detects the resume level into a sticky flag.
module usb_port_debounce
    import usb_hc_status_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] rawState,
    input  logic       resumeIn,
    input  logic       connectClr,
    input  logic       resumeClr,
    output logic [1:0] stableState,
    output logic       connectChange,
    output logic       resumeChange
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dbState_t         state, stateN;
    logic [1:0]       cand, candN;
    logic [1:0]       stableN;
    logic [CNT_W-1:0] cnt, cntN;
    logic             resPrev;
    logic             connSet, resSet;
    logic             connN, resN;

    always_comb begin
        stateN  = state;
        stableN = stableState;
        candN   = cand;
        cntN    = cnt;
        connSet = 1'b0;
        unique case (state)
            DB_STABLE: begin
                if (rawState != stableState) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        stableN = rawState;
                        connSet = 1'b1;
                    end else begin
                        stateN = DB_DEBOUNCE;
                        candN  = rawState;
                        cntN   = CNT_ONE;
                    end
                end
            end
            DB_DEBOUNCE: begin
                unique case (1'b1)
                    (rawState == cand): begin
                        if (cnt + CNT_ONE == CNT_LAST) begin
                            stableN = cand;
                            connSet = 1'b1;
                            stateN  = DB_STABLE;
                            cntN    = '0;
                        end else begin
                            cntN = cnt + CNT_ONE;
                        end
                    end
                    (rawState == stableState): begin
                        stateN = DB_STABLE;
                        cntN   = '0;
                    end
                    default: begin
                        candN = rawState;
                        cntN  = CNT_ONE;
                    end
                endcase
            end
            default: stateN = DB_STABLE;
        endcase
    end

    // Set beats a simultaneous clear.
    assign resSet = resumeIn & ~resPrev;
    assign connN  = connSet | (connectChange & ~connectClr);
    assign resN   = resSet | (resumeChange & ~resumeClr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= DB_STABLE;
            stableState   <= CONNECT_DISCONNECT;
            cand          <= CONNECT_DISCONNECT;
            cnt           <= '0;
            resPrev       <= 1'b0;
            connectChange <= 1'b0;
            resumeChange  <= 1'b0;
        end else begin
            state         <= stateN;
            stableState   <= stableN;
            cand          <= candN;
            cnt           <= cntN;
            resPrev       <= resumeIn;
            connectChange <= connN;
            resumeChange  <= resN;
        end
    end

endmodule

// File: rtl/usb_port_status_monitor.sv
// Root-hub line-status monitor: per-port debounce plus
// a registered, maskable interrupt over the sticky flags.
module usb_port_status_monitor
    import usb_hc_status_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NUM_PORTS-1:0] connectStateIn,
    input  logic [NUM_PORTS-1:0]   resumeDetectedIn,
    input  logic [NUM_PORTS-1:0]   connectChangeClr,
    input  logic [NUM_PORTS-1:0]   resumeChangeClr,
    input  logic                   connectIntEn,
    input  logic                   resumeIntEn,
    output logic [2*NUM_PORTS-1:0] connectStateOut,
    output logic [NUM_PORTS-1:0]   connectChange,
    output logic [NUM_PORTS-1:0]   resumeChange,
    output logic                   intOut
);

    logic intN;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
        usb_port_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) uDb (
            .clk          (clk),
            .rst          (rst),
            .rawState     (connectStateIn[2*p +: 2]),
            .resumeIn     (resumeDetectedIn[p]),
            .connectClr   (connectChangeClr[p]),
            .resumeClr    (resumeChangeClr[p]),
            .stableState  (connectStateOut[2*p +: 2]),
            .connectChange(connectChange[p]),
            .resumeChange (resumeChange[p])
        );
    end

    assign intN = |(connectChange & {NUM_PORTS{connectIntEn}})
                | |(resumeChange & {NUM_PORTS{resumeIntEn}});

    always_ff @(posedge clk) begin
        if (rst) intOut <= 1'b0;
        else     intOut <= intN;
    end

endmodule
